phys_reg_free_list: RTL and testbench

- Allocator and scheduler for the 64-entry physical register file used by the rename/out-of-order path.
- Hands out free physical registers to the decoder/rename stage and reclaims them when the ooo_buffer retires an instruction.
- Keeps the per-register availability vector that ooo_buffer consumes as free_list[64], where 1 means the operand has been written.
- Supports 4 branch checkpoints, so a mispredict rewinds every allocation made after the branch in one cycle.

---
 rtl/phys_reg_free_list.sv | 127 ++++++++++++
 tb/tb_phys_reg_free_list.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Free-list allocator for the physical register file.
// Hands out free pregs from a circular FIFO and takes back retired pregs.
// Keeps a readiness vector (1 = value written) and up to NUM_CKPT branch
// checkpoints, each of which can rewind the allocation head in one cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_req                rename stage wants one preg this cycle
//   alloc_grant, alloc_preg  combinational grant and the FIFO head entry
//   free_valid, free_preg    retire returns a preg (preg 0 is never freed)
//   wb_valid, wb_preg        writeback marks a preg readable
//   ckpt_take, ckpt_restore  snapshot / rewind the head using slot ckpt_id
//   free_list                registered readiness vector
//   free_count               number of entries in the free FIFO (0..NUM_PREGS)
//   overflow_err             sticky: a free arrived while the FIFO was full
module phys_reg_free_list #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_ARCH  = 32,
    parameter int unsigned NUM_CKPT  = 4,
    localparam int unsigned PW       = $clog2(NUM_PREGS),
    localparam int unsigned PTR_W    = PW + 1,
    localparam int unsigned CKW      = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic [PW-1:0]        alloc_preg,
    input  logic                 free_valid,
    input  logic [PW-1:0]        free_preg,
    input  logic                 wb_valid,
    input  logic [PW-1:0]        wb_preg,
    input  logic                 ckpt_take,
    input  logic                 ckpt_restore,
    input  logic [CKW-1:0]       ckpt_id,
    output logic [NUM_PREGS-1:0] free_list,
    output logic [PTR_W-1:0]     free_count,
    output logic                 overflow_err
);

    logic [PW-1:0]        fifo [NUM_PREGS];
    logic [PTR_W-1:0]     ckpt [NUM_CKPT];
    logic [PTR_W-1:0]     head, tail;
    logic [PTR_W-1:0]     head_n, tail_n;
    logic [PTR_W-1:0]     count;
    logic [PTR_W-1:0]     slot_sel;
    logic [PTR_W-1:0]     rewind_dist;
    logic [PW-1:0]        rewind_off;
    logic [NUM_PREGS-1:0] free_list_n;
    logic                 free_ok;
    logic                 free_accept;
    logic                 overflow_set;

    assign count      = tail - head;
    assign free_count = count;

    // Grant, free acceptance and next pointers
    always_comb begin
        alloc_grant  = alloc_req && !ckpt_restore && (count != '0);
        alloc_preg   = fifo[head[PW-1:0]];
        free_ok      = free_valid && (free_preg != '0);
        // A same-cycle grant makes room, so a full FIFO still accepts the free
        free_accept  = free_ok && ((count != PTR_W'(NUM_PREGS)) || alloc_grant);
        overflow_set = free_ok && (count == PTR_W'(NUM_PREGS)) && !alloc_grant;
        slot_sel     = ckpt[ckpt_id];
        head_n       = ckpt_restore ? slot_sel : head + PTR_W'(alloc_grant);
        tail_n       = tail + PTR_W'(free_accept);
    end

    // Readiness vector: writeback and rewind set bits, allocation clears last
    always_comb begin
        free_list_n = free_list;
        rewind_dist = head - slot_sel;
        rewind_off  = '0;
        if (wb_valid) begin
            free_list_n[wb_preg] = 1'b1;
        end
        if (ckpt_restore) begin
            // Entries between the checkpoint and the current head were handed
            // out speculatively; they return to the pool as readable.
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                rewind_off = PW'(i) - slot_sel[PW-1:0];
                if ({1'b0, rewind_off} < rewind_dist) begin
                    free_list_n[fifo[i]] = 1'b1;
                end
            end
        end
        if (alloc_grant) begin
            free_list_n[alloc_preg] = 1'b0;
        end
        free_list_n[0] = 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= PTR_W'(NUM_PREGS - NUM_ARCH);
            free_list    <= '1;
            overflow_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                ckpt[i] <= '0;
            end
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                if (i < NUM_PREGS - NUM_ARCH) begin
                    fifo[i] <= PW'(NUM_ARCH + i);
                end else begin
                    fifo[i] <= '0;
                end
            end
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            free_list <= free_list_n;
            if (overflow_set) begin
                overflow_err <= 1'b1;
            end
            if (free_accept) begin
                fifo[tail[PW-1:0]] <= free_preg;
            end
            if (ckpt_take && !ckpt_restore) begin
                ckpt[ckpt_id] <= head_n;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: queue-based reference model of
// the free FIFO, issue log for checkpoint rewinds, and a grant scoreboard.
module tb_phys_reg_free_list;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req;
    logic        alloc_grant;
    logic [5:0]  alloc_preg;
    logic        free_valid;
    logic [5:0]  free_preg;
    logic        wb_valid;
    logic [5:0]  wb_preg;
    logic        ckpt_take;
    logic        ckpt_restore;
    logic [1:0]  ckpt_id;
    logic [63:0] free_list;
    logic [6:0]  free_count;
    logic        overflow_err;

    always #5 clk = ~clk;

    phys_reg_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_preg   (alloc_preg),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .wb_valid     (wb_valid),
        .wb_preg      (wb_preg),
        .ckpt_take    (ckpt_take),
        .ckpt_restore (ckpt_restore),
        .ckpt_id      (ckpt_id),
        .free_list    (free_list),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    int          m_q[$];
    int          m_log[$];
    int          m_ckpt[4];
    logic [63:0] m_fl;
    bit          m_ovf;

    // Scoreboard: {grant, preg}, preg masked to 0 when not granted
    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];

    task automatic idle_inputs();
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_preg    = '0;
        wb_valid     = 1'b0;
        wb_preg      = '0;
        ckpt_take    = 1'b0;
        ckpt_restore = 1'b0;
        ckpt_id      = '0;
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_q.push_back(32 + i);
        m_log.delete();
        for (int i = 0; i < 4; i++) m_ckpt[i] = 0;
        m_fl  = '1;
        m_ovf = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; records expected and observed grant, then
    // advances the reference model.
    task automatic cyc(input bit req, input bit fv, input int fp, input bit wbv,
                       input int wbp, input bit take, input bit rest, input int id);
        bit g;
        int gp;
        int pre;
        int p;
        @(negedge clk);
        alloc_req    = req;
        free_valid   = fv;
        free_preg    = 6'(fp);
        wb_valid     = wbv;
        wb_preg      = 6'(wbp);
        ckpt_take    = take;
        ckpt_restore = rest;
        ckpt_id      = 2'(id);
        #1;
        pre = m_q.size();
        g   = req && !rest && (pre != 0);
        gp  = g ? m_q[0] : 0;
        exp_q.push_back({g, 6'(gp)});
        obs_q.push_back({alloc_grant, alloc_grant ? alloc_preg : 6'd0});
        @(posedge clk);
        if (wbv) m_fl[wbp] = 1'b1;
        if (rest) begin
            while (m_log.size() > m_ckpt[id]) begin
                p = m_log.pop_back();
                m_q.push_front(p);
                m_fl[p] = 1'b1;
            end
        end
        if (g) begin
            void'(m_q.pop_front());
            m_log.push_back(gp);
            m_fl[gp] = 1'b0;
        end
        if (fv && fp != 0) begin
            if (pre < 64 || g) m_q.push_back(fp);
            else m_ovf = 1'b1;
        end
        if (take && !rest) m_ckpt[id] = m_log.size();
        m_fl[0] = 1'b1;
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_preg  = 6'd5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        n_checks++; if (free_count !== 7'd32) $display("FAIL reset_count: got %0d want 32", free_count); else n_pass++;
        n_checks++; if (free_list !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL reset_free_list: got %h want all ones", free_list); else n_pass++;
        n_checks++; if (overflow_err !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_err); else n_pass++;
        n_checks++; if (alloc_grant !== 1'b0) $display("FAIL reset_grant_idle: got %b want 0", alloc_grant); else n_pass++;
        n_checks++; if (alloc_preg !== 6'd32) $display("FAIL reset_head: got %0d want 32", alloc_preg); else n_pass++;
    endtask

    task automatic test_alloc_basic();
        logic [6:0] e, o;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_q[i] !== {1'b1, 6'(32 + i)}) $display("FAIL basic_preg%0d: got %h want %h", i, obs_q[i], {1'b1, 6'(32 + i)});
            else n_pass++;
        end
        n_checks++; if (free_count !== 7'd29) $display("FAIL basic_count: got %0d want 29", free_count); else n_pass++;
        n_checks++; if (free_list !== 64'hFFFF_FFF8_FFFF_FFFF) $display("FAIL basic_free_list: got %h want FFFFFFF8FFFFFFFF", free_list); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL basic_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
    endtask

    task automatic test_empty();
        logic [6:0] e, o;
        for (int i = 0; i < 29; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== 7'h00) $display("FAIL empty_grant: got %h want 00", obs_q[obs_q.size()-1]); else n_pass++;
        n_checks++; if (free_count !== 7'd0) $display("FAIL empty_count: got %0d want 0", free_count); else n_pass++;
        cyc(0, 1, 5, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== {1'b1, 6'd5}) $display("FAIL empty_refill: got %h want %h", obs_q[obs_q.size()-1], {1'b1, 6'd5}); else n_pass++;
        // No bypass: free and request together at empty do not grant
        cyc(1, 1, 7, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== 7'h00) $display("FAIL nobypass_grant: got %h want 00", obs_q[obs_q.size()-1]); else n_pass++;
        n_checks++; if (free_count !== 7'd1) $display("FAIL nobypass_count: got %0d want 1", free_count); else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== {1'b1, 6'd7}) $display("FAIL nobypass_next: got %h want %h", obs_q[obs_q.size()-1], {1'b1, 6'd7}); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL empty_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
        n_checks++; if (free_count !== 7'(m_q.size())) $display("FAIL empty_model_count: got %0d want %0d", free_count, m_q.size()); else n_pass++;
        n_checks++; if (free_list !== m_fl) $display("FAIL empty_model_fl: got %h want %h", free_list, m_fl); else n_pass++;
    endtask

    task automatic test_checkpoint();
        logic [6:0] e, o;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 36, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        n_checks++; if (free_count !== 7'd29) $display("FAIL restore_count: got %0d want 29", free_count); else n_pass++;
        n_checks++; if (free_list !== 64'hFFFF_FFF8_FFFF_FFFF) $display("FAIL restore_free_list: got %h want FFFFFFF8FFFFFFFF", free_list); else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== {1'b1, 6'd35}) $display("FAIL restore_next: got %h want %h", obs_q[obs_q.size()-1], {1'b1, 6'd35}); else n_pass++;
        // Take together with a grant snapshots the post-grant head
        cyc(1, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Restore beats both alloc and take in the same cycle
        cyc(1, 0, 0, 0, 0, 1, 1, 1);
        n_checks++; if (obs_q[obs_q.size()-1] !== 7'h00) $display("FAIL restore_blocks_grant: got %h want 00", obs_q[obs_q.size()-1]); else n_pass++;
        n_checks++; if (free_count !== 7'd27) $display("FAIL restore2_count: got %0d want 27", free_count); else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_q[obs_q.size()-1] !== {1'b1, 6'd37}) $display("FAIL restore2_next: got %h want %h", obs_q[obs_q.size()-1], {1'b1, 6'd37}); else n_pass++;
        // Restore with a concurrent free: tail still advances
        cyc(0, 1, 12, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL ckpt_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
        n_checks++; if (free_count !== 7'(m_q.size())) $display("FAIL ckpt_model_count: got %0d want %0d", free_count, m_q.size()); else n_pass++;
        n_checks++; if (free_list !== m_fl) $display("FAIL ckpt_model_fl: got %h want %h", free_list, m_fl); else n_pass++;
    endtask

    task automatic test_writeback();
        logic [6:0] e, o;
        do_reset();
        cyc(1, 0, 0, 1, 32, 0, 0, 0);
        n_checks++; if (free_list[32] !== 1'b0) $display("FAIL wb_alloc_wins: got %b want 0", free_list[32]); else n_pass++;
        cyc(0, 0, 0, 1, 32, 0, 0, 0);
        n_checks++; if (free_list[32] !== 1'b1) $display("FAIL wb_set: got %b want 1", free_list[32]); else n_pass++;
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 33, 0, 0, 0);
        n_checks++; if (free_list[0] !== 1'b1) $display("FAIL wb_zero: got %b want 1", free_list[0]); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL wb_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
        n_checks++; if (free_list !== m_fl) $display("FAIL wb_model_fl: got %h want %h", free_list, m_fl); else n_pass++;
    endtask

    task automatic test_free_overflow();
        logic [6:0] e, o;
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (free_count !== 7'd32) $display("FAIL free_zero_count: got %0d want 32", free_count); else n_pass++;
        for (int i = 1; i <= 32; i++) cyc(0, 1, i, 0, 0, 0, 0, 0);
        n_checks++; if (free_count !== 7'd64) $display("FAIL full_count: got %0d want 64", free_count); else n_pass++;
        n_checks++; if (overflow_err !== 1'b0) $display("FAIL full_no_ovf: got %b want 0", overflow_err); else n_pass++;
        cyc(0, 1, 9, 0, 0, 0, 0, 0);
        n_checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_err); else n_pass++;
        n_checks++; if (free_count !== 7'd64) $display("FAIL ovf_count: got %0d want 64", free_count); else n_pass++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_err); else n_pass++;
        // Full FIFO with a grant still accepts the free
        cyc(1, 1, 10, 0, 0, 0, 0, 0);
        n_checks++; if (free_count !== 7'd64) $display("FAIL full_alloc_free_count: got %0d want 64", free_count); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL ovf_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
        n_checks++; if (overflow_err !== m_ovf) $display("FAIL ovf_model: got %b want %b", overflow_err, m_ovf); else n_pass++;
        do_reset();
        n_checks++; if (overflow_err !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow_err); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [6:0] e, o;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1, (i % 63) + 1, 0, 0, 0, 0, 0);
            n_checks++;
            if (free_count !== 7'd32) begin
                if (bad < 5) $display("FAIL wrap_count: cycle %0d got %0d want 32", i, free_count);
                bad++;
            end else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL wrap_sb: got g=%b p=%0d want g=%b p=%0d", o[6], o[5:0], e[6], e[5:0]); else n_pass++;
        end
        n_checks++; if (free_list !== m_fl) $display("FAIL wrap_model_fl: got %h want %h", free_list, m_fl); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_alloc_basic();
        test_empty();
        test_checkpoint();
        test_writeback();
        test_free_overflow();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
